// File: rtl/xdcr_map_pkg.sv
// Shared types for the transducer output mapper.
//   commit_state_t : commit state machine encoding
//   map_entry_t    : one pin's table entry {valid, ch}
//   identity_entry : reset value of a pin's entry
package xdcr_map_pkg;

  // Channel field is sized for the largest supported DEPTH; users only ever
  // load the low $clog2(DEPTH) bits, the rest stay zero.
  localparam int unsigned CH_W_MAX = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } commit_state_t;

  typedef struct packed {
    logic                valid;
    logic [CH_W_MAX-1:0] ch;
  } map_entry_t;

  // Pin p drives channel p when such a channel exists, otherwise tied low.
  function automatic map_entry_t identity_entry(input int unsigned pin,
                                                input int unsigned depth);
    map_entry_t e;
    e.valid = (pin < depth);
    e.ch    = (pin < depth) ? CH_W_MAX'(pin) : '0;
    return e;
  endfunction

endpackage

// File: rtl/xdcr_out_mapper_if.sv
// Table programming / commit port of xdcr_out_mapper.
//   MAP_WE/MAP_ADDR/MAP_CH/MAP_VALID : shadow-table write strobe and payload
//   COMMIT                           : request shadow -> active swap
//   COMMIT_BUSY/MAP_ERR/TIMEOUT_ERR  : status back to the host
interface xdcr_out_mapper_if #(
  parameter int unsigned DEPTH    = 249,
  parameter int unsigned NUM_PINS = 252
);
  localparam int unsigned PIN_W = $clog2(NUM_PINS);
  localparam int unsigned CH_W  = $clog2(DEPTH);

  logic             MAP_WE;
  logic [PIN_W-1:0] MAP_ADDR;
  logic [CH_W-1:0]  MAP_CH;
  logic             MAP_VALID;
  logic             COMMIT;
  logic             COMMIT_BUSY;
  logic             MAP_ERR;
  logic             TIMEOUT_ERR;

  modport master (
    output MAP_WE, MAP_ADDR, MAP_CH, MAP_VALID, COMMIT,
    input  COMMIT_BUSY, MAP_ERR, TIMEOUT_ERR
  );

  modport slave (
    input  MAP_WE, MAP_ADDR, MAP_CH, MAP_VALID, COMMIT,
    output COMMIT_BUSY, MAP_ERR, TIMEOUT_ERR
  );

endinterface

// File: rtl/xdcr_map_table.sv
// Double-buffered pin map: shadow table written one pin at a time, copied
// whole into the active table on swap. Both reset to identity.
//   clk, rst_n           : clock, synchronous active-low reset
//   wr_en/wr_addr/wr_valid/wr_ch : pre-qualified shadow write
//   swap                 : copy shadow into active this cycle
//   active               : active table, one entry per pin
module xdcr_map_table
  import xdcr_map_pkg::*;
#(
  parameter int unsigned DEPTH    = 249,
  parameter int unsigned NUM_PINS = 252,
  localparam int unsigned PIN_W   = $clog2(NUM_PINS),
  localparam int unsigned CH_W    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [PIN_W-1:0]             wr_addr,
  input  logic                         wr_valid,
  input  logic [CH_W-1:0]              wr_ch,
  input  logic                         swap,
  output map_entry_t [NUM_PINS-1:0]    active
);

  map_entry_t shadow [NUM_PINS];

  // Shadow write port and single-cycle shadow -> active copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < NUM_PINS; p++) begin
        shadow[p] <= identity_entry(p, DEPTH);
        active[p] <= identity_entry(p, DEPTH);
      end
    end else begin
      if (wr_en) begin
        shadow[wr_addr] <= '{valid: wr_valid, ch: CH_W_MAX'(wr_ch)};
      end
      if (swap) begin
        for (int unsigned p = 0; p < NUM_PINS; p++) begin
          active[p] <= shadow[p];
        end
      end
    end
  end

endmodule

// File: rtl/xdcr_out_mapper.sv
// Transducer output stage: maps DEPTH logical PWM channels onto NUM_PINS
// physical pins through a runtime-programmable, double-buffered table.
//   CLK, RESET_N : clock, synchronous active-low reset
//   PWM_IN       : logical channel PWM bits
//   SYNC         : frame sync pulse; a pending commit swaps on it
//   FORCE_OFF    : level; drives every pin low while high
//   XDCR_OUT     : registered pin outputs
//   map          : table write / commit / status port
module xdcr_out_mapper
  import xdcr_map_pkg::*;
#(
  parameter int unsigned DEPTH    = 249,
  parameter int unsigned NUM_PINS = 252,
  parameter int unsigned TIMEOUT  = 25600
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [DEPTH-1:0]     PWM_IN,
  input  logic                 SYNC,
  input  logic                 FORCE_OFF,
  output logic [NUM_PINS-1:0]  XDCR_OUT,
  xdcr_out_mapper_if.slave     map
);

  localparam int unsigned CH_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  commit_state_t             state;
  logic [CNT_W-1:0]          cnt;
  logic                      busy_q;
  logic                      map_err_q;
  logic                      tmo_err_q;
  logic                      wr_ok_c;
  logic                      swap_c;
  logic [NUM_PINS-1:0]       xdcr_d_c;
  map_entry_t [NUM_PINS-1:0] active;

  // Write qualification; writes are only taken while no commit is pending.
  always_comb begin
    wr_ok_c = map.MAP_WE && (state == IDLE) &&
              (32'(map.MAP_ADDR) < NUM_PINS) &&
              (!map.MAP_VALID || (32'(map.MAP_CH) < DEPTH));
    swap_c  = (state == PENDING) && SYNC;
  end

  xdcr_map_table #(
    .DEPTH    (DEPTH),
    .NUM_PINS (NUM_PINS)
  ) u_table (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .wr_en    (wr_ok_c),
    .wr_addr  (map.MAP_ADDR),
    .wr_valid (map.MAP_VALID),
    .wr_ch    (map.MAP_CH),
    .swap     (swap_c),
    .active   (active)
  );

  // Commit state machine, timeout counter and error flags.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= IDLE;
      cnt       <= '0;
      busy_q    <= 1'b0;
      map_err_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      map_err_q <= map.MAP_WE && !wr_ok_c;
      case (state)
        IDLE: begin
          // A SYNC coincident with COMMIT is not used; the swap waits.
          if (map.COMMIT) begin
            state     <= PENDING;
            cnt       <= '0;
            busy_q    <= 1'b1;
            tmo_err_q <= 1'b0;
          end
        end
        PENDING: begin
          // cnt is TIMEOUT-1 on the TIMEOUT-th edge after the COMMIT edge.
          if (SYNC) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            tmo_err_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Per-pin source mux. The channel range guard never trips for accepted
  // writes; it keeps a pin from ever selecting outside PWM_IN.
  always_comb begin
    xdcr_d_c = '0;
    for (int unsigned p = 0; p < NUM_PINS; p++) begin
      xdcr_d_c[p] = !FORCE_OFF && active[p].valid &&
                    (active[p].ch < CH_W_MAX'(DEPTH)) &&
                    PWM_IN[CH_W'(active[p].ch)];
    end
  end

  // Output register stage.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      XDCR_OUT <= '0;
    end else begin
      XDCR_OUT <= xdcr_d_c;
    end
  end

  assign map.COMMIT_BUSY = busy_q;
  assign map.MAP_ERR     = map_err_q;
  assign map.TIMEOUT_ERR = tmo_err_q;

endmodule

// File: tb/tb_xdcr_out_mapper.sv
// Directed bench for xdcr_out_mapper (DEPTH=249, NUM_PINS=252, TIMEOUT=100).
module tb_xdcr_out_mapper;

  localparam int unsigned DEPTH    = 249;
  localparam int unsigned NUM_PINS = 252;

  logic                clk;
  logic                rst_n;
  logic [DEPTH-1:0]    pwm;
  logic                sync;
  logic                force_off;
  logic [NUM_PINS-1:0] xout;

  int errors = 0;
  int checks = 0;

  xdcr_out_mapper_if #(.DEPTH(DEPTH), .NUM_PINS(NUM_PINS)) mif ();

  xdcr_out_mapper #(
    .DEPTH    (DEPTH),
    .NUM_PINS (NUM_PINS),
    .TIMEOUT  (100)
  ) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .PWM_IN    (pwm),
    .SYNC      (sync),
    .FORCE_OFF (force_off),
    .XDCR_OUT  (xout),
    .map       (mif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [DEPTH-1:0]    pwm;
    logic                foff;
    logic [NUM_PINS-1:0] exp;
  } vec_t;

  vec_t vt [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [NUM_PINS-1:0] act,
                         input logic [NUM_PINS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wr(input int unsigned addr, input int unsigned ch, input logic v);
    mif.MAP_WE    = 1'b1;
    mif.MAP_ADDR  = 8'(addr);
    mif.MAP_CH    = 8'(ch);
    mif.MAP_VALID = v;
  endtask

  task automatic wr_clear();
    mif.MAP_WE    = 1'b0;
    mif.MAP_ADDR  = '0;
    mif.MAP_CH    = '0;
    mif.MAP_VALID = 1'b0;
  endtask

  initial begin
    logic [DEPTH-1:0] ones;
    logic [DEPTH-1:0] tmp;
    int busy_cnt;

    ones = '1;

    // Identity-mapping vectors: pin p = channel p, pins 249..251 low.
    tmp = '0; tmp[5] = 1'b1;
    vt[0] = '{pwm: tmp, foff: 1'b0, exp: {3'b000, tmp}};
    vt[1] = '{pwm: ones, foff: 1'b0, exp: {3'b000, ones}};
    vt[2] = '{pwm: ones, foff: 1'b1, exp: '0};
    tmp = '0;
    for (int i = 0; i < int'(DEPTH); i++) tmp[i] = (i % 2 == 1);
    vt[3] = '{pwm: tmp, foff: 1'b0, exp: {3'b000, tmp}};
    tmp = '0; tmp[0] = 1'b1; tmp[248] = 1'b1;
    vt[4] = '{pwm: tmp, foff: 1'b0, exp: {3'b000, tmp}};
    vt[5] = '{pwm: '0, foff: 1'b0, exp: '0};

    rst_n = 1'b0; pwm = ones; sync = 1'b0; force_off = 1'b0;
    mif.COMMIT = 1'b0;
    wr_clear();

    // Reset: outputs low even with every channel high.
    step(); step();
    chk_vec("reset_xout", xout, '0);
    chk_bit("reset_busy", mif.COMMIT_BUSY, 1'b0);
    chk_bit("reset_map_err", mif.MAP_ERR, 1'b0);
    chk_bit("reset_tmo_err", mif.TIMEOUT_ERR, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      pwm = vt[i].pwm;
      force_off = vt[i].foff;
      step();
      chk_vec($sformatf("vec%0d", i), xout, vt[i].exp);
    end

    // FORCE_OFF high across three edges: exactly three zero cycles.
    pwm = ones;
    for (int i = 0; i < 6; i++) begin
      force_off = (i >= 1 && i <= 3);
      step();
      chk_vec($sformatf("force_off_%0d", i), xout,
              (i >= 1 && i <= 3) ? '0 : {3'b000, ones});
    end
    force_off = 1'b0;

    // Remap pin 0 to ch 248, commit, SYNC ten cycles after the commit edge.
    pwm = '0; pwm[0] = 1'b1;
    wr(0, 248, 1'b1);
    step();
    wr_clear();
    chk_bit("remap_wr_err", mif.MAP_ERR, 1'b0);
    mif.COMMIT = 1'b1;
    step();
    mif.COMMIT = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i <= 11; i++) begin
      if (mif.COMMIT_BUSY) busy_cnt++;
      chk_bit($sformatf("remap_pin0_%0d", i), xout[0], (i <= 10));
      sync = (i == 9);
      step();
    end
    sync = 1'b0;
    chk_int("remap_busy_cycles", busy_cnt, 10);
    pwm = '0; pwm[248] = 1'b1;
    step();
    chk_bit("remap_pin0_ch248", xout[0], 1'b1);
    chk_bit("remap_pin248_kept", xout[248], 1'b1);

    // Write rejection and boundary acceptance.
    pwm = '0;
    wr(252, 0, 1'b0);
    step();
    wr_clear();
    chk_bit("err_addr_252", mif.MAP_ERR, 1'b1);
    step();
    chk_bit("err_pulse_one_cycle", mif.MAP_ERR, 1'b0);
    wr(1, 249, 1'b1);
    step();
    wr_clear();
    chk_bit("err_ch_249", mif.MAP_ERR, 1'b1);
    wr(251, 249, 1'b0);
    step();
    chk_bit("ok_ch_249_invalid", mif.MAP_ERR, 1'b0);
    wr(251, 248, 1'b1);
    step();
    chk_bit("ok_pin_251", mif.MAP_ERR, 1'b0);
    wr(3, 10, 1'b1);
    mif.COMMIT = 1'b1;
    step();
    mif.COMMIT = 1'b0;
    wr_clear();
    chk_bit("we_commit_err", mif.MAP_ERR, 1'b0);
    chk_bit("we_commit_busy", mif.COMMIT_BUSY, 1'b1);
    wr(2, 7, 1'b1);
    step();
    wr_clear();
    chk_bit("err_pending_write", mif.MAP_ERR, 1'b1);
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk_bit("swap2_busy", mif.COMMIT_BUSY, 1'b0);
    pwm = '0; pwm[2] = 1'b1; pwm[10] = 1'b1; pwm[248] = 1'b1; pwm[1] = 1'b1;
    step();
    chk_bit("pin2_unchanged", xout[2], 1'b1);
    chk_bit("pin3_ch10", xout[3], 1'b1);
    chk_bit("pin251_ch248", xout[251], 1'b1);
    chk_bit("pin1_unchanged", xout[1], 1'b1);
    pwm = '0; pwm[3] = 1'b1; pwm[7] = 1'b1;
    step();
    chk_bit("pin3_ch10_low", xout[3], 1'b0);
    chk_bit("pin251_low", xout[251], 1'b0);
    chk_bit("pin2_ignores_ch7", xout[2], 1'b0);

    // COMMIT and SYNC together while idle: swap waits for the next SYNC.
    wr(4, 9, 1'b1);
    step();
    wr_clear();
    mif.COMMIT = 1'b1; sync = 1'b1;
    step();
    mif.COMMIT = 1'b0; sync = 1'b0;
    chk_bit("commit_sync_busy", mif.COMMIT_BUSY, 1'b1);
    pwm = '0; pwm[4] = 1'b1;
    step();
    chk_bit("commit_sync_noswap", xout[4], 1'b1);
    chk_bit("commit_sync_busy2", mif.COMMIT_BUSY, 1'b1);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk_bit("commit_sync_done", mif.COMMIT_BUSY, 1'b0);
    step();
    chk_bit("pin4_ch9", xout[4], 1'b0);

    // Timeout: no SYNC, a repeated COMMIT mid-wait must not restart it.
    wr(5, 20, 1'b1);
    step();
    wr_clear();
    pwm = '0; pwm[5] = 1'b1;
    mif.COMMIT = 1'b1;
    step();
    mif.COMMIT = 1'b0;
    chk_bit("tmo_start_busy", mif.COMMIT_BUSY, 1'b1);
    chk_bit("tmo_start_err", mif.TIMEOUT_ERR, 1'b0);
    for (int i = 1; i <= 100; i++) begin
      mif.COMMIT = (i == 50);
      step();
      if (i == 99) begin
        chk_bit("tmo_99_busy", mif.COMMIT_BUSY, 1'b1);
        chk_bit("tmo_99_err", mif.TIMEOUT_ERR, 1'b0);
      end
      if (i == 100) begin
        chk_bit("tmo_100_busy", mif.COMMIT_BUSY, 1'b0);
        chk_bit("tmo_100_err", mif.TIMEOUT_ERR, 1'b1);
      end
    end
    mif.COMMIT = 1'b0;
    chk_bit("tmo_active_kept", xout[5], 1'b1);
    step(); step();
    chk_bit("tmo_err_sticky", mif.TIMEOUT_ERR, 1'b1);
    mif.COMMIT = 1'b1;
    step();
    mif.COMMIT = 1'b0;
    chk_bit("tmo_err_cleared", mif.TIMEOUT_ERR, 1'b0);
    chk_bit("tmo_recommit_busy", mif.COMMIT_BUSY, 1'b1);
    sync = 1'b1;
    step();
    sync = 1'b0;
    step();
    chk_bit("tmo_shadow_kept", xout[5], 1'b0);
    pwm = '0; pwm[20] = 1'b1;
    step();
    chk_bit("pin5_ch20", xout[5], 1'b1);

    // Reset while a commit is pending: identity restored, no later swap.
    wr(0, 100, 1'b1);
    step();
    wr_clear();
    mif.COMMIT = 1'b1;
    step();
    mif.COMMIT = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_bit("rst_pend_busy", mif.COMMIT_BUSY, 1'b0);
    chk_vec("rst_pend_xout", xout, '0);
    pwm = '0; pwm[0] = 1'b1;
    step();
    chk_vec("rst_identity_pin0", xout, NUM_PINS'(1));
    sync = 1'b1;
    step();
    sync = 1'b0;
    step();
    chk_vec("rst_no_swap", xout, NUM_PINS'(1));
    chk_bit("rst_no_swap_busy", mif.COMMIT_BUSY, 1'b0);
    pwm = ones;
    step();
    chk_vec("rst_identity_all", xout, {3'b000, ones});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
